cordic_seq_ctrl: RTL and testbench
==================================

# cordic_seq_ctrl

Sequencer for the circular CORDIC shift-add datapath. It accepts a start request and loads the datapath x/y registers. It then steps the shift index `i` through `N_ITER` micro-rotations, choosing the rotation direction `delta` each cycle, and accumulates the residual angle `z` against an arctangent table. It supports rotation mode (drive z to 0) and vectoring mode (drive y to 0), and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 16: word width of x, y and z.
- `N_ITER`, 16: number of micro-rotations; legal range 1..16 (`i` is 4 bits).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  0 = rotation, 1 = vectoring; captured with `start`.
- `z0`  in  WIDTH  signed initial angle; captured with `start`.
- `y_sign`  in  1  MSB of datapath `y_i`; used in vectoring mode.
- `ld`  out  1  drives datapath `async_LD`.
- `i`  out  4  shift index to the datapath.
- `delta`  out  1  rotation direction to the datapath.
- `busy`  out  1  high in LOAD and ITER.
- `done`  out  1  one-cycle completion pulse.
- `z_out`  out  WIDTH  signed residual or accumulated angle; valid while `done` is high and held until the next accepted start.

## Operation
- **Angle format:** binary angle; ±π maps to ±2^(WIDTH-1), so π/4 = 2^(WIDTH-3) (8192 at WIDTH=16).
- **delta convention:**
  - delta=1 means x' = x − (y>>>i), y' = y + (x>>>i), z' = z − atan(2^-i).
  - delta=0 means the opposite signs.
- **delta source:**
  - Rotation mode: delta = ~z[WIDTH-1] (z ≥ 0 → 1).
  - Vectoring mode: delta = y_sign (y < 0 → 1).
  - delta is combinational from the registered z, or from the `y_sign` input.
- **States:**
  - IDLE: if `start`, go to LOAD; capture z ← z0 and latch mode.
  - LOAD: `ld`=1 for exactly one cycle; i=0. In vectoring mode, z is cleared to 0 here; in rotation mode it keeps z0. Go to ITER.
  - ITER: each cycle, z ← z ∓ ATAN[i] per delta and i ← i+1. When i = N_ITER−1, go to DONE.
  - DONE: `done`=1 for one cycle; go to IDLE.
- **Arithmetic:** z add/subtract is WIDTH-bit two's complement wrapping. ATAN entries are rounded to nearest. No gain compensation is applied in this block; the caller pre-scales by K.
- **Reset values:** state=IDLE, ld=0, i=0, busy=0, done=0, z=0, z_out=0, mode=0. delta follows its combinational rule.
- **Boundary conditions:**
  - `start` in LOAD, ITER or DONE is ignored and not queued.
  - `rst` asserted mid-operation forces IDLE immediately with all outputs at reset values. The datapath contents are then don't-care.
  - `i` never exceeds N_ITER−1; it returns to 0 in DONE and IDLE.
  - `ld` is never high outside LOAD.

## Timing
- `start` sampled high at edge k gives: LOAD in cycle k+1, ITER in cycles k+2 .. k+N_ITER+1, and `done` high in cycle k+N_ITER+2.
- Datapath x/y are final during the `done` cycle.
- Earliest next start is sampled at edge k+N_ITER+3, giving a throughput of one operation per N_ITER+3 cycles.
- `ld`, `i`, `busy`, `done` and `z_out` are registered outputs (glitch-free for the asynchronous load).

## Structure
- Package `cordic_pkg` holds:
  - the state enum: IDLE, LOAD, ITER, DONE;
  - the ATAN table `function atan_lut(int idx, int width)` as 16 WIDTH-scaled constants (8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0 at WIDTH=16);
  - the mode encodings.
- One sub-module is natural: `cordic_z_accum`, containing the z register and the add/subtract against ATAN[i]. The FSM and iteration counter stay at the top level.

## Test plan
- **Protocol:** start with N_ITER=16 → `ld` high for exactly one cycle at k+1; `i` steps 0..15 over k+2..k+17; `done` is a single pulse at k+18; `busy` is high k+1..k+17.
- **Rotation:** X=9949, Y=0, z0=8192, mode=0 with the datapath attached → in the `done` cycle, x and y are each 11585±4 and `z_out` is within ±2 of 0.
- **Vectoring:** X=16384, Y=16384, mode=1 → `z_out`=8192±2, y within ±4 of 0, x ≈ 23170/K scaled (38155±8).
- **Start while busy:** `start` pulsed at k+5 and at k+18 → both ignored; no second `ld`; only one `done`.
- **Reset mid-run:** `rst` asserted during ITER at i=7 → in the same cycle busy=0, ld=0, i=0, z_out=0. A later start then runs a clean full sequence.
- **Negative angle:** rotation with z0=−8192, X=9949, Y=0 → y = −11585±4; the delta sequence begins with 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, mode encodings and arctangent table for the CORDIC sequencer
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // atan(2^-idx) in binary-angle units where pi maps to 2^(width-1)
  function automatic int atan_lut(input int idx, input int width);
    int base;
    case (idx)
      0:       base = 8192;
      1:       base = 4836;
      2:       base = 2555;
      3:       base = 1297;
      4:       base = 651;
      5:       base = 326;
      6:       base = 163;
      7:       base = 81;
      8:       base = 41;
      9:       base = 20;
      10:      base = 10;
      11:      base = 5;
      12:      base = 3;
      13:      base = 1;
      14:      base = 1;
      default: base = 0;
    endcase
    if (width >= 16) atan_lut = base <<< (width - 16);
    else             atan_lut = base >>> (16 - width);
  endfunction

endpackage

// File: rtl/cordic_z_accum.sv
// rtl/cordic_z_accum.sv - residual angle register with add/subtract against the arctangent table
module cordic_z_accum
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    step,
  input  logic                    delta,
  input  logic [3:0]              idx,
  input  logic signed [WIDTH-1:0] z0,
  output logic signed [WIDTH-1:0] z,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [WIDTH-1:0] atan_val;

  assign atan_val = WIDTH'(atan_lut(int'(idx), WIDTH));
  assign z_next   = delta ? (z - atan_val) : (z + atan_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        z <= '0;
    else if (load)  z <= z0;
    else if (clear) z <= '0;
    else if (step)  z <= z_next;
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - FSM and shift-index counter sequencing the CORDIC shift-add datapath
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N_ITER = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] z0,
  input  logic                    y_sign,
  output logic                    ld,
  output logic [3:0]              i,
  output logic                    delta,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] z_out
);

  state_t                  state;
  logic                    mode_r;
  logic signed [WIDTH-1:0] z;
  logic signed [WIDTH-1:0] z_next;
  logic                    accept;

  assign accept = (state == IDLE) && start;
  assign delta  = (mode_r == MODE_VEC) ? y_sign : ~z[WIDTH-1];

  cordic_z_accum #(.WIDTH(WIDTH)) u_z_accum (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .clear  ((state == LOAD) && (mode_r == MODE_VEC)),
    .step   (state == ITER),
    .delta  (delta),
    .idx    (i),
    .z0     (z0),
    .z      (z),
    .z_next (z_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ld     <= 1'b0;
      i      <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z_out  <= '0;
      mode_r <= MODE_ROT;
    end else begin
      case (state)
        IDLE: begin
          i    <= 4'd0;
          done <= 1'b0;
          if (start) begin
            state  <= LOAD;
            ld     <= 1'b1;
            busy   <= 1'b1;
            mode_r <= mode;
          end
        end
        LOAD: begin
          state <= ITER;
          ld    <= 1'b0;
          i     <= 4'd0;
        end
        ITER: begin
          // z_out captures the final micro-rotation's result as it is written
          if (i == 4'(N_ITER - 1)) begin
            state <= DONE;
            i     <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            z_out <= z_next;
          end else begin
            i <= i + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ld    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          i     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - directed-vector bench for cordic_seq_ctrl with a behavioural shift-add datapath
module tb_cordic_seq_ctrl;

  localparam int WIDTH  = 16;
  localparam int N_ITER = 16;

  logic                    clk   = 1'b0;
  logic                    rst   = 1'b1;
  logic                    start = 1'b0;
  logic                    mode  = 1'b0;
  logic signed [WIDTH-1:0] z0    = '0;
  logic                    y_sign;
  logic                    ld;
  logic [3:0]              i;
  logic                    delta;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] z_out;

  logic signed [31:0] dx     = 0;
  logic signed [31:0] dy     = 0;
  logic signed [31:0] x_init = 0;
  logic signed [31:0] y_init = 0;

  int checks = 0;
  int errors = 0;

  cordic_seq_ctrl #(.WIDTH(WIDTH), .N_ITER(N_ITER)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .z0     (z0),
    .y_sign (y_sign),
    .ld     (ld),
    .i      (i),
    .delta  (delta),
    .busy   (busy),
    .done   (done),
    .z_out  (z_out)
  );

  always #5 clk = ~clk;

  assign y_sign = dy[31];

  // wide datapath so the unscaled CORDIC gain cannot overflow
  always @(posedge clk) begin
    if (ld) begin
      dx <= x_init;
      dy <= y_init;
    end else if (busy) begin
      if (delta) begin
        dx <= dx - (dy >>> i);
        dy <= dy + (dx >>> i);
      end else begin
        dx <= dx + (dy >>> i);
        dy <= dy - (dx >>> i);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    int diff;
    checks++;
    diff = (got > exp) ? (got - exp) : (exp - got);
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic m, input int zin, input int xin, input int yin,
                        input int pa, input int pb,
                        output int zo, output int xo, output int yo, output int d0);
    int exp_i;
    zo = 0; xo = 0; yo = 0; d0 = -1;
    mode   = m;
    z0     = WIDTH'(zin);
    x_init = xin;
    y_init = yin;
    start  = 1'b1;
    for (int c = 1; c <= N_ITER + 4; c++) begin
      tick;
      start = 1'b0;
      exp_i = (c >= 2 && c <= N_ITER + 1) ? c - 2 : 0;
      check($sformatf("ld c%0d", c),   int'(ld),   int'(c == 1));
      check($sformatf("busy c%0d", c), int'(busy), int'(c <= N_ITER + 1));
      check($sformatf("done c%0d", c), int'(done), int'(c == N_ITER + 2));
      check($sformatf("i c%0d", c),    int'(i),    exp_i);
      if (c == 2) d0 = int'(delta);
      if (c == N_ITER + 2) begin
        zo = int'(z_out);
        xo = dx;
        yo = dy;
      end
      if (c == pa || c == pb) start = 1'b1;
    end
  endtask

  initial begin
    int zo, xo, yo, d0, n;
    bit found;

    tick;
    tick;
    check("rst ld",    int'(ld),    0);
    check("rst busy",  int'(busy),  0);
    check("rst done",  int'(done),  0);
    check("rst i",     int'(i),     0);
    check("rst z_out", int'(z_out), 0);
    check("rst delta", int'(delta), 1);
    rst = 1'b0;
    tick;

    // rotation by +pi/4 with stray starts during ITER and DONE
    run_op(1'b0, 8192, 9949, 0, 5, 18, zo, xo, yo, d0);
    check("rot z_out",  zo, 0, 2);
    check("rot x",      xo, 11585, 4);
    check("rot y",      yo, 11585, 4);
    check("rot delta0", d0, 1);

    // vectoring: z0 must be discarded in LOAD
    run_op(1'b1, 1234, 16384, 16384, -1, -1, zo, xo, yo, d0);
    check("vec z_out", zo, 8192, 2);
    check("vec y",     yo, 0, 4);
    check("vec x",     xo, 38155, 8);

    // reset in the middle of ITER
    mode   = 1'b0;
    z0     = 16'sd8192;
    x_init = 9949;
    y_init = 0;
    start  = 1'b1;
    found  = 1'b0;
    n      = 0;
    while (!found && n < 40) begin
      tick;
      start = 1'b0;
      n++;
      if (busy && i == 4'd7) found = 1'b1;
    end
    check("rst_wait i7", int'(found), 1);
    rst = 1'b1;
    #1;
    check("midrst busy",  int'(busy),  0);
    check("midrst ld",    int'(ld),    0);
    check("midrst i",     int'(i),     0);
    check("midrst done",  int'(done),  0);
    check("midrst z_out", int'(z_out), 0);
    tick;
    rst = 1'b0;
    tick;

    run_op(1'b0, 8192, 9949, 0, -1, -1, zo, xo, yo, d0);
    check("post-rst z_out", zo, 0, 2);
    check("post-rst x",     xo, 11585, 4);
    check("post-rst y",     yo, 11585, 4);

    // negative angle
    run_op(1'b0, -8192, 9949, 0, -1, -1, zo, xo, yo, d0);
    check("neg delta0", d0, 0);
    check("neg y",      yo, -11585, 4);
    check("neg x",      xo, 11585, 4);
    check("neg z_out",  zo, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
